packet_sink: RTL



---
 rtl/packet_sink_if.sv | 22 ++
 rtl/packet_sink.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_sink_if.sv
// packet_sink_if: router local-output handshake into the ejection endpoint.
// The router (master) drives the flit and its valid; the sink (slave) drives en.
interface packet_sink_if #(
  parameter int TIME_W = 32
);

  typedef struct packed {
    logic [3:0]        x_dest;
    logic [3:0]        y_dest;
    logic              ant;
    logic              measure;
    logic [TIME_W-1:0] timestamp;
  } packet_t;

  packet_t data;
  logic    data_val;
  logic    en;

  modport master (output data, output data_val, input en);
  modport slave  (input data, input data_val, output en);

endinterface

// File: rtl/packet_sink.sv
// packet_sink: mesh NoC ejection endpoint. Buffers arriving flits in a small
// FIFO, drains them at the consumer's pace, counts received / misrouted / ant
// packets, and runs an IDLE -> WARMUP -> MEASURE -> DONE phase machine.
// Optional feature macro SINK_LATENCY_EN: when defined, latency sum/max
// statistics are built; when undefined, o_lat_sum and o_lat_max are tied to 0.
module packet_sink #(
  parameter int          X_LOC           = 0,
  parameter int          Y_LOC           = 0,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          TIME_W          = 32,
  parameter int unsigned WARMUP_PACKETS  = 1000,
  parameter int unsigned MEASURE_PACKETS = 5000
) (
  input  logic               clk,
  input  logic               reset,
  packet_sink_if.slave       rx,
  input  logic [TIME_W-1:0]  i_time,
  input  logic               i_drain_en,
  input  logic               i_start,
  output logic [1:0]         o_state,
  output logic               o_done,
  output logic [31:0]        o_rx_count,
  output logic [15:0]        o_misroute_count,
  output logic [15:0]        o_ant_count,
  output logic [TIME_W+15:0] o_lat_sum,
  output logic [TIME_W-1:0]  o_lat_max,
  output logic               o_overflow
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = TIME_W + 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [WORD_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              alive_q;
  logic              overflow_q, overflow_d;
  logic [31:0]       rx_count_q, rx_count_d;
  logic [15:0]       mis_count_q, mis_count_d;
  logic [15:0]       ant_count_q, ant_count_d;
  state_t            state_q, state_d;
  logic [31:0]       phase_cnt_q, phase_cnt_d, phase_cnt_inc;

  logic              full, empty, en, push, pop;
  logic [WORD_W-1:0] push_word, pop_word;
  logic [3:0]        pop_x, pop_y;
  logic              pop_ant, pop_meas;
  logic [TIME_W-1:0] pop_ts;

  // alive_q holds o_en low until the first clock after reset releases.
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty     = (count_q == '0);
  assign en        = alive_q & ~full;
  assign rx.en     = en;
  assign push      = rx.data_val & en;
  assign pop       = i_drain_en & ~empty;
  assign push_word = rx.data;
  assign pop_word  = mem_q[rd_ptr_q];
  assign pop_x     = pop_word[WORD_W-1 -: 4];
  assign pop_y     = pop_word[WORD_W-5 -: 4];
  assign pop_ant   = pop_word[TIME_W+1];
  assign pop_meas  = pop_word[TIME_W];
  assign pop_ts    = pop_word[TIME_W-1:0];
  assign phase_cnt_inc = phase_cnt_q + 32'(pop);

  // FIFO storage; contents need no reset because count_q gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // FIFO pointers, occupancy, sticky overflow and saturating packet counters.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d  = overflow_q | (rx.data_val & ~en);
    rx_count_d  = rx_count_q;
    mis_count_d = mis_count_q;
    ant_count_d = ant_count_q;
    if (pop) begin
      if (rx_count_q != '1) rx_count_d = rx_count_q + 32'd1;
      if (((pop_x != 4'(X_LOC)) || (pop_y != 4'(Y_LOC))) && (mis_count_q != '1))
        mis_count_d = mis_count_q + 16'd1;
      if (pop_ant && (ant_count_q != '1)) ant_count_d = ant_count_q + 16'd1;
    end
  end

  // Phase machine; the pop that completes a phase is counted in that phase.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = (WARMUP_PACKETS == 0) ? ST_MEASURE : ST_WARMUP;
          phase_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        phase_cnt_d = phase_cnt_inc;
        if (phase_cnt_inc >= WARMUP_PACKETS) begin
          state_d     = ST_MEASURE;
          phase_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        phase_cnt_d = phase_cnt_inc;
        if (phase_cnt_inc >= MEASURE_PACKETS) begin
          state_d     = ST_DONE;
          phase_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // Register all control state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alive_q     <= 1'b0;
      overflow_q  <= 1'b0;
      rx_count_q  <= '0;
      mis_count_q <= '0;
      ant_count_q <= '0;
      state_q     <= ST_IDLE;
      phase_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alive_q     <= 1'b1;
      overflow_q  <= overflow_d;
      rx_count_q  <= rx_count_d;
      mis_count_q <= mis_count_d;
      ant_count_q <= ant_count_d;
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

  assign o_state          = state_q;
  assign o_done           = (state_q == ST_DONE);
  assign o_rx_count       = rx_count_q;
  assign o_misroute_count = mis_count_q;
  assign o_ant_count      = ant_count_q;
  assign o_overflow       = overflow_q;

`ifdef SINK_LATENCY_EN
  localparam int SUM_W = TIME_W + 16;

  logic [TIME_W-1:0] latency;
  logic [SUM_W:0]    sum_wide;
  logic [SUM_W-1:0]  lat_sum_q, lat_sum_d;
  logic [TIME_W-1:0] lat_max_q, lat_max_d;

  assign latency  = i_time - pop_ts;
  assign sum_wide = {1'b0, lat_sum_q} + {17'b0, latency};

  // Accumulate saturating latency sum and running max for measured packets.
  always_comb begin
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    if (pop && (state_q == ST_MEASURE) && pop_meas) begin
      lat_sum_d = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
      if (latency > lat_max_q) lat_max_d = latency;
    end
  end

  // Latency statistic registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_sum_q <= '0;
      lat_max_q <= '0;
    end else begin
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign o_lat_sum = lat_sum_q;
  assign o_lat_max = lat_max_q;
`else
  logic unused_lat;
  assign unused_lat = ^{i_time, pop_ts, pop_meas};
  assign o_lat_sum  = '0;
  assign o_lat_max  = '0;
`endif

endmodule
